// File: rtl/ex_stage_front.sv
// Execute-stage front end: ID/EX pipeline register, ALU control decode,
// EX/MEM and MEM/WB operand forwarding, and load-use hazard detection.
module ex_stage_front #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [1:0]      id_aluop,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic            id_memtoreg,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_regwrite,
  input  logic [RW-1:0]   exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [RW-1:0]   memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_memtoreg,
  output logic            ex_valid,
  output logic            ex_illegal,
  output logic            load_use_stall
);

  logic [XLEN-1:0] q_rs1_data, q_rs2_data, q_imm;
  logic [RW-1:0]   q_rs1, q_rs2;
  logic [1:0]      q_aluop;
  logic [2:0]      q_funct3;
  logic            q_funct7b5, q_alusrc;
  logic            illegal;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Pipeline control: stall freezes ID/EX; flush or a load-use hazard
  // replaces the incoming instruction with an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && load_use_stall)) begin
      ex_valid    <= 1'b0;
      q_rs1_data  <= '0;
      q_rs2_data  <= '0;
      q_imm       <= '0;
      q_rs1       <= '0;
      q_rs2       <= '0;
      ex_rd       <= '0;
      q_aluop     <= 2'b00;
      q_funct3    <= 3'b000;
      q_funct7b5  <= 1'b0;
      q_alusrc    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memtoreg <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      q_rs1_data  <= id_rs1_data;
      q_rs2_data  <= id_rs2_data;
      q_imm       <= id_imm;
      q_rs1       <= id_rs1;
      q_rs2       <= id_rs2;
      ex_rd       <= id_rd;
      q_aluop     <= id_aluop;
      q_funct3    <= id_funct3;
      q_funct7b5  <= id_funct7b5;
      q_alusrc    <= id_alusrc;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_branch   <= id_branch;
      ex_memtoreg <= id_memtoreg;
    end
  end

  always_comb begin
    load_use_stall = 1'b0;
    if (!stall && ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
        ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && !id_alusrc)))
      load_use_stall = 1'b1;
  end

  always_comb begin
    alu_ctl = 4'b1111;
    illegal = 1'b0;
    case (q_aluop)
      2'b00: alu_ctl = 4'b0010;
      2'b01: alu_ctl = 4'b0110;
      2'b10: begin
        case (q_funct3)
          // funct7b5 only selects sub for register-register forms
          3'b000:  alu_ctl = (q_funct7b5 && !q_alusrc) ? 4'b0110 : 4'b0010;
          3'b111:  alu_ctl = 4'b0000;
          3'b110:  alu_ctl = 4'b0001;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ex_illegal = ex_valid & illegal;

  function automatic logic [XLEN-1:0] fwd(
    input logic [RW-1:0]   idx,
    input logic [XLEN-1:0] regval,
    input logic            em_we,
    input logic [RW-1:0]   em_rd,
    input logic [XLEN-1:0] em_val,
    input logic            mw_we,
    input logic [RW-1:0]   mw_rd,
    input logic [XLEN-1:0] mw_val
  );
    if (em_we && (em_rd != '0) && (em_rd == idx))      return em_val;
    else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) return mw_val;
    else                                               return regval;
  endfunction

  always_comb begin
    fwd_rs1 = fwd(q_rs1, q_rs1_data, exmem_regwrite, exmem_rd, exmem_result,
                  memwb_regwrite, memwb_rd, memwb_data);
    fwd_rs2 = fwd(q_rs2, q_rs2_data, exmem_regwrite, exmem_rd, exmem_result,
                  memwb_regwrite, memwb_rd, memwb_data);
  end

  assign alu_op1       = fwd_rs1;
  assign alu_op2       = q_alusrc ? q_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_ex_stage_front.sv
// Self-checking bench for ex_stage_front: decode vector table through a
// scoreboard queue, plus forwarding, load-use, stall/flush and reset sequences.
module tb_ex_stage_front;
  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int W    = 4 + 64 + 64 + 1 + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd;
  logic [1:0]      id_aluop;
  logic [2:0]      id_funct3;
  logic            id_funct7b5, id_alusrc, id_regwrite, id_memread;
  logic            id_memwrite, id_branch, id_memtoreg;
  logic            stall, flush;
  logic            exmem_regwrite, memwb_regwrite;
  logic [RW-1:0]   exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_result, memwb_data;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_op1, alu_op2, ex_store_data;
  logic [RW-1:0]   ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_memtoreg;
  logic            ex_valid, ex_illegal, load_use_stall;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ex_stage_front #(.XLEN(XLEN), .RW(RW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_aluop(id_aluop), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_branch(id_branch), .id_memtoreg(id_memtoreg),
    .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_memtoreg(ex_memtoreg), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
    .load_use_stall(load_use_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] aluop;
    logic [2:0] funct3;
    logic       f7b5;
    logic       alusrc;
    logic [3:0] exp_ctl;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [1:0] aluop, input logic [2:0] f3,
                          input logic f7, input logic alusrc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                          input logic rw, input logic mr);
    id_valid = v; id_aluop = aluop; id_funct3 = f3; id_funct7b5 = f7; id_alusrc = alusrc;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_regwrite = rw; id_memread = mr;
    id_memwrite = 1'b0; id_branch = 1'b0; id_memtoreg = 1'b0;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  initial begin
    logic [W-1:0] got;
    logic [63:0]  d1, d2, imm;
    logic [63:0]  hold_op1;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    drive_id(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 64'd5, 64'd3, 64'd0, 1'b1, 1'b1);

    // reset held two cycles with a valid instruction presented
    tick(); tick();
    check("reset_valid", ex_valid, 0);
    check("reset_regwrite", ex_regwrite, 0);
    check("reset_memread", ex_memread, 0);
    check("reset_rd", ex_rd, 0);
    check("reset_alu_ctl", alu_ctl, 4'b0010);
    check("reset_lus", load_use_stall, 0);
    check("reset_op1", alu_op1, 0);
    check("reset_illegal", ex_illegal, 0);
    reset = 1'b0;

    // decode table
    vecs[0] = '{1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 4'b0010, 1'b0};
    vecs[2] = '{1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[3] = '{1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[4] = '{1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[5] = '{1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 4'b0010, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 4'b0110, 1'b0};
    vecs[7] = '{1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[8] = '{1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[9] = '{1'b0, 2'b10, 3'b001, 1'b0, 1'b0, 4'b1111, 1'b0};

    for (int i = 0; i < 10; i++) begin
      d1  = {32'h0, $urandom_range(1, 32'hFFFF_FFFF)};
      d2  = {32'h0, $urandom_range(1, 32'hFFFF_FFFF)};
      imm = (i == 1) ? 64'd7 : {48'h0, 16'($urandom_range(0, 16'hFFFF))};
      drive_id(vecs[i].valid, vecs[i].aluop, vecs[i].funct3, vecs[i].f7b5, vecs[i].alusrc,
               5'd1, 5'd2, 5'd3, d1, d2, imm, 1'b1, 1'b0);
      exp_q.push_back({vecs[i].exp_ctl, d1, (vecs[i].alusrc ? imm : d2),
                       vecs[i].exp_ill, vecs[i].valid});
      tick();
      got = exp_q.pop_front();
      check($sformatf("vec%0d_ctl", i), alu_ctl, got[133:130]);
      check($sformatf("vec%0d_op1", i), alu_op1, got[129:66]);
      check($sformatf("vec%0d_op2", i), alu_op2, got[65:2]);
      check($sformatf("vec%0d_illegal", i), ex_illegal, got[1]);
      check($sformatf("vec%0d_valid", i), ex_valid, got[0]);
      check($sformatf("vec%0d_store", i), ex_store_data, d2);
    end

    // forwarding priority on rs1 = x4
    drive_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 5'd4, 5'd4, 5'd9, 64'h11, 64'h22, 64'h0, 1'b1, 1'b0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 64'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_data = 64'hBB;
    #1;
    check("fwd_both_op1", alu_op1, 64'hAA);
    check("fwd_both_store", ex_store_data, 64'hAA);
    exmem_regwrite = 1'b0;
    #1;
    check("fwd_memwb_op1", alu_op1, 64'hBB);
    check("fwd_memwb_op2", alu_op2, 64'hBB);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    check("fwd_rd0_op1", alu_op1, 64'h11);
    check("fwd_rd0_op2", alu_op2, 64'h22);

    // x0 is never forwarded; rs2 forwarding reaches store data under alusrc
    exmem_result = 64'hCC;
    drive_id(1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 5'd0, 5'd7, 5'd0, 64'h0, 64'h55, 64'h40, 1'b0, 1'b0);
    tick();
    check("x0_op1", alu_op1, 64'h0);
    exmem_rd = 5'd7; exmem_result = 64'hDD;
    #1;
    check("st_op2_imm", alu_op2, 64'h40);
    check("st_store_fwd", ex_store_data, 64'hDD);
    clear_fwd();

    // load-use: ld x6 in EX, add with rs2=x6 in ID
    drive_id(1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 64'h1000, 64'h0, 64'h8, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd6, 5'd7, 64'h100, 64'h200, 64'h0, 1'b1, 1'b0);
    #1;
    check("lu_rs2_stall", load_use_stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_regwrite", ex_regwrite, 0);
    check("lu_bubble_memread", ex_memread, 0);
    check("lu_after_bubble", load_use_stall, 0);
    memwb_regwrite = 1'b1; memwb_rd = 5'd6; memwb_data = 64'h66;
    tick();
    check("lu_dep_valid", ex_valid, 1);
    check("lu_dep_op2_fwd", alu_op2, 64'h66);
    check("lu_dep_op1", alu_op1, 64'h100);
    clear_fwd();

    drive_id(1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 64'h1000, 64'h0, 64'h8, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 5'd1, 5'd6, 5'd7, 64'h100, 64'h200, 64'h5, 1'b1, 1'b0);
    #1;
    check("lu_addi_no_stall", load_use_stall, 0);
    id_rs1 = 5'd6;
    #1;
    check("lu_rs1_stall", load_use_stall, 1);
    stall = 1'b1;
    #1;
    check("lu_masked_by_stall", load_use_stall, 0);
    id_valid = 1'b0; stall = 1'b0;
    #1;
    check("lu_id_invalid", load_use_stall, 0);

    // stall holds ID/EX for three cycles
    drive_id(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 5'd3, 5'd4, 5'd12, 64'hA1, 64'hB2, 64'h0, 1'b1, 1'b0);
    tick();
    hold_op1 = alu_op1;
    check("pre_stall_op1", hold_op1, 64'hA1);
    stall = 1'b1;
    drive_id(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 5'd8, 5'd9, 5'd13, 64'hC3, 64'hD4, 64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_rd", c), ex_rd, 5'd12);
      check($sformatf("stall%0d_ctl", c), alu_ctl, 4'b0000);
      check($sformatf("stall%0d_op1", c), alu_op1, 64'hA1);
      check($sformatf("stall%0d_op2", c), alu_op2, 64'hB2);
      check($sformatf("stall%0d_valid", c), ex_valid, 1);
      check($sformatf("stall%0d_regwrite", c), ex_regwrite, 1);
    end
    flush = 1'b1;
    tick();
    check("flush_stall_valid", ex_valid, 0);
    check("flush_stall_regwrite", ex_regwrite, 0);
    check("flush_stall_rd", ex_rd, 0);
    flush = 1'b0; stall = 1'b0;

    // reset mid-stream wins over stall
    drive_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 5'd14, 64'h1, 64'h2, 64'h0, 1'b1, 1'b0);
    tick();
    check("mid_loaded_valid", ex_valid, 1);
    reset = 1'b1; stall = 1'b1;
    tick();
    check("mid_reset_valid", ex_valid, 0);
    check("mid_reset_rd", ex_rd, 0);
    reset = 1'b0; stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
